// File: rtl/wb_regfile_pkg.sv
// Shared processor package for the write-back register file.
// Holds the default register/datapath width, the default register index
// width and the index of the hard-wired zero register.
package wb_regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int ZERO_REG_IDX = 0;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB stage, the decode-stage read ports and the
// forwarding outputs of the register file.
//   master : drives memwb_* write-back controls/data and rs/rt read indices,
//            observes rs/rt read data and the registered forward outputs.
//   slave  : the register file side (mirror of master).
interface wb_regfile_if import wb_regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [DATA_W-1:0] memwb_result;
  logic [DATA_W-1:0] memwb_readdata;
  logic              memwb_memtoreg;
  logic              memwb_regdst;
  logic              memwb_regwrite;
  logic              memwb_branch;
  logic [ADDR_W-1:0] memwb_rd;
  logic [ADDR_W-1:0] memwb_rt;

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_reg;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output memwb_result, memwb_readdata, memwb_memtoreg, memwb_regdst,
           memwb_regwrite, memwb_branch, memwb_rd, memwb_rt,
           rs_addr, rt_addr,
    input  rs_data, rt_data, fwd_valid, fwd_reg, fwd_data
  );

  modport slave (
    input  memwb_result, memwb_readdata, memwb_memtoreg, memwb_regdst,
           memwb_regwrite, memwb_branch, memwb_rd, memwb_rt,
           rs_addr, rt_addr,
    output rs_data, rt_data, fwd_valid, fwd_reg, fwd_data
  );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// Write-back selection mux.
//   result/readdata/memtoreg -> wb_data (load data or ALU result)
//   rd/rt/regdst             -> wb_dst  (destination register index)
// Purely combinational.
module wb_mux import wb_regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] readdata,
  input  logic              memtoreg,
  input  logic              regdst,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_dst
);

  // A plain 2:1 select keeps an unknown readdata from leaking into wb_data
  // while the ALU result is selected.
  always_comb begin
    wb_data = result;
    wb_dst  = rt;
    if (memtoreg) wb_data = readdata;
    if (regdst)   wb_dst  = rd;
  end

endmodule

// File: rtl/wb_regfile.sv
// Register file with write-through bypass and a registered forward port.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : wb_regfile_if.slave -- MEM/WB write-back inputs,
//                combinational rs/rt read ports, registered fwd_* outputs
// Register 0 always reads zero; writes to it are discarded.
module wb_regfile import wb_regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  wb_regfile_if.slave bus
);

  localparam int                NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG_IDX);

  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] wb_dst;
  logic              wb_en;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic              fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0] fwd_reg_q,   fwd_reg_d;
  logic [DATA_W-1:0] fwd_data_q,  fwd_data_d;

  wb_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wb_mux (
    .result   (bus.memwb_result),
    .readdata (bus.memwb_readdata),
    .memtoreg (bus.memwb_memtoreg),
    .regdst   (bus.memwb_regdst),
    .rd       (bus.memwb_rd),
    .rt       (bus.memwb_rt),
    .wb_data  (wb_data),
    .wb_dst   (wb_dst)
  );

  // Reset gates the enable so a write-back coinciding with reset is neither
  // stored nor bypassed to the read ports.
  assign wb_en = bus.memwb_regwrite & ~bus.memwb_branch
               & (wb_dst != ZERO_IDX) & ~reset;

  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[wb_dst] = wb_data;
  end

  // Read ports: zero register first, then same-cycle bypass, then storage.
  always_comb begin
    bus.rs_data = regs_q[bus.rs_addr];
    if (bus.rs_addr == ZERO_IDX)                bus.rs_data = '0;
    else if (wb_en && (bus.rs_addr == wb_dst))  bus.rs_data = wb_data;
  end

  always_comb begin
    bus.rt_data = regs_q[bus.rt_addr];
    if (bus.rt_addr == ZERO_IDX)                bus.rt_data = '0;
    else if (wb_en && (bus.rt_addr == wb_dst))  bus.rt_data = wb_data;
  end

  // Forward register: index/data hold their last retired write-back.
  always_comb begin
    fwd_valid_d = wb_en;
    fwd_reg_d   = fwd_reg_q;
    fwd_data_d  = fwd_data_q;
    if (wb_en) begin
      fwd_reg_d  = wb_dst;
      fwd_data_d = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q      <= '{default: '0};
      fwd_valid_q <= 1'b0;
      fwd_reg_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      regs_q      <= regs_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_reg_q   <= fwd_reg_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign bus.fwd_valid = fwd_valid_q;
  assign bus.fwd_reg   = fwd_reg_q;
  assign bus.fwd_data  = fwd_data_q;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register and datapath width.
REQ-002 Parameter ADDR_W, default 5, register index width; register count = 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memwb_result  input  DATA_W  ALU result from the MEM/WB stage register.
REQ-006 memwb_readdata  input  DATA_W  load data from the MEM/WB stage register.
REQ-007 memwb_memtoreg  input  1  1 = write back readdata, 0 = write back result.
REQ-008 memwb_regdst  input  1  1 = destination is memwb_rd, 0 = destination is memwb_rt.
REQ-009 memwb_regwrite  input  1  write-back request.
REQ-010 memwb_branch  input  1  branch in WB; suppresses write-back.
REQ-011 memwb_rd, memwb_rt  input  ADDR_W each  candidate destination indices.
REQ-012 rs_addr, rt_addr  input  ADDR_W each  decode-stage read indices.
REQ-013 rs_data, rt_data  output  DATA_W each  decode-stage read data.
REQ-014 fwd_valid  output  1  registered: a write-back retired last cycle.
REQ-015 fwd_reg  output  ADDR_W  registered index of that write-back.
REQ-016 fwd_data  output  DATA_W  registered data of that write-back.

Function
REQ-017 wb_data SHALL be memwb_readdata when memwb_memtoreg=1, else memwb_result.
REQ-018 wb_dst SHALL be memwb_rd when memwb_regdst=1, else memwb_rt.
REQ-019 wb_en SHALL be memwb_regwrite AND NOT memwb_branch AND wb_dst!=0 AND NOT reset.
REQ-020 When wb_en=1, register[wb_dst] SHALL take wb_data at the next posedge clk; otherwise storage is unchanged.
REQ-021 Register 0 SHALL read 0 at all times; writes to it are discarded.
REQ-022 Reads SHALL be combinational (zero-cycle latency) from rs_addr/rt_addr.
REQ-023 Write-through bypass: when wb_en=1 and a read index equals wb_dst, that read port SHALL return wb_data in the same cycle.
REQ-024 Both read ports SHALL bypass independently; rs_addr=rt_addr=wb_dst returns wb_data on both.
REQ-025 fwd_valid/fwd_reg/fwd_data SHALL register wb_en/wb_dst/wb_data each posedge (one-cycle latency); fwd_reg and fwd_data SHALL hold their previous value when wb_en=0, fwd_valid drops to 0.
REQ-026 Back-to-back writes to the same index SHALL leave the later value; no write is dropped or reordered.
REQ-027 X on memwb_readdata SHALL not propagate when memwb_memtoreg=0.

Reset
REQ-028 On posedge clk with reset=1, all registers SHALL clear to 0, fwd_valid=0, fwd_reg=0, fwd_data=0.
REQ-029 A write-back presented in the same cycle as reset SHALL be discarded, and no bypass SHALL occur in that cycle.
REQ-030 Reset asserted mid-sequence SHALL leave no residual register contents; the first write after deassertion proceeds normally.

Structure
REQ-031 DATA_W, ADDR_W defaults and the zero-register index constant SHALL live in the shared processor package.
REQ-032 Write-back mux (REQ-017/018) SHALL be a separate sub-module wb_mux; storage, bypass and forward register stay in wb_regfile.

Verification
REQ-033 Reset, then read all 32 indices -> every rs_data/rt_data = 0, fwd_valid=0.
REQ-034 regwrite=1, regdst=1, rd=5, memtoreg=0, result=0xDEADBEEF; rs_addr=5 same cycle -> rs_data=0xDEADBEEF (bypass); next cycle fwd_valid=1, fwd_reg=5, fwd_data=0xDEADBEEF; reg5 reads 0xDEADBEEF thereafter.
REQ-035 regwrite=1, regdst=0, rt=9, memtoreg=1, readdata=0x12345678, result=0xFFFFFFFF -> reg9=0x12345678.
REQ-036 Write 0xCAFEF00D to index 0 -> rs_addr=0 returns 0 in that cycle and after; fwd_valid=0 next cycle.
REQ-037 regwrite=1 with branch=1, rd=7, result=0x1 -> reg7 unchanged (0), fwd_valid=0.
REQ-038 Write reg3=0xAA, then reset asserted same cycle as write reg4=0xBB -> after reset reg3=0, reg4=0, fwd_valid=0.
